not8bit_checker: RTL and testbench
==================================

NOT8BIT_CHECKER -- requirements
Module: not8bit_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the checked inverter.
REQ-002 SHALL have parameter NUM_TESTS, default 5, number of vector pairs per run (1..255).
REQ-003 SHALL have port clk input 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-005 SHALL have port start input 1: a one-cycle pulse that begins a run.
REQ-006 SHALL have port vec_valid input 1: a vector pair is present on vec_in and vec_out.
REQ-007 SHALL have port vec_ready output 1: the checker accepts the pair this cycle.
REQ-008 SHALL have port vec_in input WIDTH: the stimulus applied to the inverter.
REQ-009 SHALL have port vec_out input WIDTH: the inverter response.
REQ-010 SHALL have port test_idx output 8: index of the next pair to be checked.
REQ-011 SHALL have port pass_count output 8: number of matching pairs in the current run.
REQ-012 SHALL have port fail_count output 8: number of mismatching pairs in the current run.
REQ-013 SHALL have port done output 1: the run is complete.
REQ-014 SHALL have port all_passed output 1: run complete with fail_count == 0.
REQ-015 SHALL have ports err_valid output 1, err_idx output 8, err_in output WIDTH, err_out output WIDTH: capture of the first failing pair.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE->RUN on start; this transition SHALL clear test_idx, the pass/fail counts, done, all_passed and err_valid in the same edge.
REQ-018 vec_ready SHALL be 1 only in RUN; a pair SHALL transfer on a cycle with vec_valid && vec_ready.
REQ-019 On each transfer SHALL compute expected = ~vec_in (bitwise, WIDTH bits) and compare it with vec_out using a 4-state-safe equality; X/Z on any bit of vec_out SHALL count as a fail.
REQ-020 Counts and test_idx SHALL update one edge after the transfer, giving a latency of 1 cycle.
REQ-021 On the first fail of a run, SHALL latch err_idx=test_idx, err_in and err_out, and set err_valid; later fails SHALL NOT overwrite the capture.
REQ-022 The transfer with test_idx == NUM_TESTS-1 SHALL move RUN->DONE at the same edge; done=1 and all_passed=(fail_count==0, including this last pair) SHALL be valid the next cycle.
REQ-023 In DONE, outputs SHALL hold; start SHALL go DONE->RUN with the clears of REQ-017.
REQ-024 start while in RUN SHALL restart the run (clear and stay in RUN); when start coincides with a transfer, start wins and the pair SHALL be discarded.
REQ-025 vec_valid with no transfer (IDLE/DONE) SHALL be ignored without any state change.
REQ-026 Counters SHALL NOT wrap: NUM_TESTS<=255 bounds them.

Reset
REQ-027 While rst_n is low, SHALL force the state to IDLE, set vec_ready=0, test_idx=0, pass_count=0, fail_count=0, done=0, all_passed=0, err_valid=0, err_idx=0, err_in=0, err_out=0.
REQ-028 Reset asserted mid-run SHALL abort the run; the next run SHALL require a new start.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH/NUM_TESTS constants.
REQ-030 The compare SHALL be a sub-module inv_compare (combinational: in, out -> match), reusable for other gate checkers.

Verification
REQ-031 Reset, start, then the 5 pairs 00/FF, FF/00, AA/55, 3C/C3, 12/ED -> pass_count=5, fail_count=0, done=1, all_passed=1, err_valid=0.
REQ-032 Same run with pair 2 given as AA/54 -> fail_count=1, pass_count=4, all_passed=0, err_idx=2, err_in=AA, err_out=54.
REQ-033 Two failing pairs (idx 1 and 3) -> err_idx stays 1, fail_count=2.
REQ-034 vec_out=8'hXX on pair 0 -> counted as a fail, err_valid=1, err_idx=0.
REQ-035 rst_n pulled low after 3 transfers -> all outputs at reset values; vec_valid held high in IDLE -> test_idx stays 0.
REQ-036 start asserted in the same cycle as transfer #2 -> counts 0 and test_idx 0 the next cycle, state stays RUN.

Source files
------------

// File: rtl/not8bit_checker_pkg.sv
// Shared definitions for the inverter checker: FSM encoding and default sizing.
package not8bit_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_TESTS = 5;

endpackage

// File: rtl/not8bit_checker_inv_compare.sv
// Combinational inverter response check: match is 1 only when out_vec is
// exactly ~in_vec, so an unknown bit on out_vec never reads as a match.
module inv_compare #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_vec,
  input  logic [WIDTH-1:0] out_vec,
  output logic             match
);

  // Case equality keeps X/Z on the response from slipping through as a pass.
  always_comb begin
    match = ((~in_vec) === out_vec);
  end

endmodule

// File: rtl/not8bit_checker.sv
// Run-based checker for a WIDTH-bit inverter: accepts NUM_TESTS vector pairs,
// counts matches/mismatches and captures the first failing pair.
module not8bit_checker
  import not8bit_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_TESTS = DEF_NUM_TESTS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_in,
  input  logic [WIDTH-1:0] vec_out,
  output logic [7:0]       test_idx,
  output logic [7:0]       pass_count,
  output logic [7:0]       fail_count,
  output logic             done,
  output logic             all_passed,
  output logic             err_valid,
  output logic [7:0]       err_idx,
  output logic [WIDTH-1:0] err_in,
  output logic [WIDTH-1:0] err_out
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_TESTS - 1);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       pass_q, pass_d;
  logic [7:0]       fail_q, fail_d;
  logic             done_q, done_d;
  logic             allp_q, allp_d;
  logic             errv_q, errv_d;
  logic [7:0]       err_idx_q, err_idx_d;
  logic [WIDTH-1:0] err_in_q, err_in_d;
  logic [WIDTH-1:0] err_out_q, err_out_d;
  logic             match_s;

  inv_compare #(.WIDTH(WIDTH)) u_cmp (
    .in_vec  (vec_in),
    .out_vec (vec_out),
    .match   (match_s)
  );

  // Next-state and run bookkeeping; start wins over a coincident transfer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    done_d    = done_q;
    allp_d    = allp_q;
    errv_d    = errv_q;
    err_idx_d = err_idx_q;
    err_in_d  = err_in_q;
    err_out_d = err_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 8'd0;
          pass_d  = 8'd0;
          fail_d  = 8'd0;
          done_d  = 1'b0;
          allp_d  = 1'b0;
          errv_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 8'd0;
          pass_d  = 8'd0;
          fail_d  = 8'd0;
          done_d  = 1'b0;
          allp_d  = 1'b0;
          errv_d  = 1'b0;
        end else if (vec_valid && ready_q) begin
          idx_d = idx_q + 8'd1;
          if (match_s) begin
            pass_d = pass_q + 8'd1;
          end else begin
            fail_d = fail_q + 8'd1;
            if (!errv_q) begin
              errv_d    = 1'b1;
              err_idx_d = idx_q;
              err_in_d  = vec_in;
              err_out_d = vec_out;
            end else begin
              errv_d = errv_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            allp_d  = (fail_d == 8'd0);
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      idx_q     <= 8'd0;
      pass_q    <= 8'd0;
      fail_q    <= 8'd0;
      done_q    <= 1'b0;
      allp_q    <= 1'b0;
      errv_q    <= 1'b0;
      err_idx_q <= 8'd0;
      err_in_q  <= '0;
      err_out_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      allp_q    <= allp_d;
      errv_q    <= errv_d;
      err_idx_q <= err_idx_d;
      err_in_q  <= err_in_d;
      err_out_q <= err_out_d;
    end
  end

  assign vec_ready  = ready_q;
  assign test_idx   = idx_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign done       = done_q;
  assign all_passed = allp_q;
  assign err_valid  = errv_q;
  assign err_idx    = err_idx_q;
  assign err_in     = err_in_q;
  assign err_out    = err_out_q;

endmodule

// File: tb/tb_not8bit_checker.sv
// Directed bench for not8bit_checker: inputs change and outputs are sampled on
// the falling edge, the DUT acts on the rising edge.
module tb_not8bit_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       vec_valid;
  logic       vec_ready;
  logic [7:0] vec_in;
  logic [7:0] vec_out;
  logic [7:0] test_idx;
  logic [7:0] pass_count;
  logic [7:0] fail_count;
  logic       done;
  logic       all_passed;
  logic       err_valid;
  logic [7:0] err_idx;
  logic [7:0] err_in;
  logic [7:0] err_out;

  int passed = 0;
  int total  = 0;

  not8bit_checker #(.WIDTH(8), .NUM_TESTS(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_in     (vec_in),
    .vec_out    (vec_out),
    .test_idx   (test_idx),
    .pass_count (pass_count),
    .fail_count (fail_count),
    .done       (done),
    .all_passed (all_passed),
    .err_valid  (err_valid),
    .err_idx    (err_idx),
    .err_in     (err_in),
    .err_out    (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] vi, input logic [7:0] vo);
    vec_valid = 1'b1;
    vec_in    = vi;
    vec_out   = vo;
    check("send_ready", {31'd0, vec_ready}, 32'd1);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   {31'd0, vec_ready},  32'd0);
    check({tag, "_idx"},     {24'd0, test_idx},   32'd0);
    check({tag, "_pass"},    {24'd0, pass_count}, 32'd0);
    check({tag, "_fail"},    {24'd0, fail_count}, 32'd0);
    check({tag, "_done"},    {31'd0, done},       32'd0);
    check({tag, "_allp"},    {31'd0, all_passed}, 32'd0);
    check({tag, "_errv"},    {31'd0, err_valid},  32'd0);
    check({tag, "_erridx"},  {24'd0, err_idx},    32'd0);
    check({tag, "_errin"},   {24'd0, err_in},     32'd0);
    check({tag, "_errout"},  {24'd0, err_out},    32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec_in    = 8'h00;
    vec_out   = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run: all five pairs invert correctly.
    pulse_start();
    check("r1_ready", {31'd0, vec_ready}, 32'd1);
    send(8'h00, 8'hFF);
    check("r1_lat_idx",  {24'd0, test_idx},   32'd1);
    check("r1_lat_pass", {24'd0, pass_count}, 32'd1);
    send(8'hFF, 8'h00);
    send(8'hAA, 8'h55);
    send(8'h3C, 8'hC3);
    send(8'h12, 8'hED);
    check("r1_pass", {24'd0, pass_count}, 32'd5);
    check("r1_fail", {24'd0, fail_count}, 32'd0);
    check("r1_done", {31'd0, done},       32'd1);
    check("r1_allp", {31'd0, all_passed}, 32'd1);
    check("r1_errv", {31'd0, err_valid},  32'd0);
    check("r1_idx",  {24'd0, test_idx},   32'd5);
    check("r1_ready_done", {31'd0, vec_ready}, 32'd0);

    // Valid pairs offered in DONE must be ignored.
    vec_valid = 1'b1;
    vec_in    = 8'h0F;
    vec_out   = 8'h0F;
    repeat (3) @(negedge clk);
    vec_valid = 1'b0;
    check("done_hold_idx",  {24'd0, test_idx},   32'd5);
    check("done_hold_fail", {24'd0, fail_count}, 32'd0);
    check("done_hold_done", {31'd0, done},       32'd1);

    // One bad pair at index 2.
    pulse_start();
    check("r2_clr_pass", {24'd0, pass_count}, 32'd0);
    check("r2_clr_done", {31'd0, done},       32'd0);
    check("r2_clr_allp", {31'd0, all_passed}, 32'd0);
    send(8'h00, 8'hFF);
    send(8'hFF, 8'h00);
    send(8'hAA, 8'h54);
    send(8'h3C, 8'hC3);
    send(8'h12, 8'hED);
    check("r2_pass",   {24'd0, pass_count}, 32'd4);
    check("r2_fail",   {24'd0, fail_count}, 32'd1);
    check("r2_done",   {31'd0, done},       32'd1);
    check("r2_allp",   {31'd0, all_passed}, 32'd0);
    check("r2_errv",   {31'd0, err_valid},  32'd1);
    check("r2_erridx", {24'd0, err_idx},    32'd2);
    check("r2_errin",  {24'd0, err_in},     32'hAA);
    check("r2_errout", {24'd0, err_out},    32'h54);

    // Bad pairs at 1 and 3: the first capture must stick.
    pulse_start();
    check("r3_clr_errv", {31'd0, err_valid}, 32'd0);
    send(8'h00, 8'hFF);
    send(8'hFF, 8'h01);
    send(8'hAA, 8'h55);
    send(8'h3C, 8'hC2);
    send(8'h12, 8'hED);
    check("r3_fail",   {24'd0, fail_count}, 32'd2);
    check("r3_pass",   {24'd0, pass_count}, 32'd3);
    check("r3_erridx", {24'd0, err_idx},    32'd1);
    check("r3_errin",  {24'd0, err_in},     32'hFF);
    check("r3_errout", {24'd0, err_out},    32'h01);

    // Unknown response bits on pair 0 count as a fail.
    pulse_start();
    send(8'h00, 8'bxxxx_xxx0);
    check("rx_fail",   {24'd0, fail_count}, 32'd1);
    check("rx_errv",   {31'd0, err_valid},  32'd1);
    check("rx_erridx", {24'd0, err_idx},    32'd0);
    send(8'hFF, 8'h00);
    send(8'hAA, 8'h55);
    send(8'h3C, 8'hC3);
    send(8'h12, 8'hED);
    check("rx_pass", {24'd0, pass_count}, 32'd4);
    check("rx_allp", {31'd0, all_passed}, 32'd0);

    // Reset after three transfers aborts the run.
    pulse_start();
    send(8'h00, 8'hFF);
    send(8'hFF, 8'h00);
    send(8'hAA, 8'h00);
    check("r5_idx",  {24'd0, test_idx},  32'd3);
    check("r5_errv", {31'd0, err_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n     = 1'b1;
    vec_valid = 1'b1;
    vec_in    = 8'h00;
    vec_out   = 8'hFF;
    repeat (3) @(negedge clk);
    vec_valid = 1'b0;
    check("idle_idx",   {24'd0, test_idx},   32'd0);
    check("idle_pass",  {24'd0, pass_count}, 32'd0);
    check("idle_ready", {31'd0, vec_ready},  32'd0);

    // Start coinciding with transfer #2 restarts and drops the pair.
    pulse_start();
    send(8'h00, 8'hFF);
    send(8'hFF, 8'h00);
    vec_valid = 1'b1;
    vec_in    = 8'hAA;
    vec_out   = 8'h55;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    vec_valid = 1'b0;
    check("rs_idx",   {24'd0, test_idx},   32'd0);
    check("rs_pass",  {24'd0, pass_count}, 32'd0);
    check("rs_fail",  {24'd0, fail_count}, 32'd0);
    check("rs_ready", {31'd0, vec_ready},  32'd1);
    check("rs_done",  {31'd0, done},       32'd0);
    send(8'h00, 8'hFF);
    send(8'hFF, 8'h00);
    send(8'hAA, 8'h55);
    send(8'h3C, 8'hC3);
    send(8'h12, 8'hED);
    check("rs_end_pass", {24'd0, pass_count}, 32'd5);
    check("rs_end_allp", {31'd0, all_passed}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
